imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot sequencer for the single-cycle CPU. Accepts a program as a valid/ready stream of 32-bit instruction words, writes them into the CPU's instruction memory through the `initialize`/`instruction_initialize_data`/`instruction_initialize_address` port, and holds the CPU in reset until the image is written. It then releases the CPU so execution starts at PC 0, and supports reload and error recovery without a global reset.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: maximum image size in words (instruction memory capacity).
- `HOLD_CYCLES`, 2: cycles the CPU reset stays asserted after the last write completes; legal values are ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle request to begin a load session.
- `load_valid` in 1: stream word valid.
- `load_ready` out 1: stream word ready.
- `load_data` in 32: instruction word.
- `load_last` in 1: marks the final word of the image.
- `initialize` out 1: instruction memory write strobe.
- `instruction_initialize_data` out 32: word to write.
- `instruction_initialize_address` out 32: byte address to write.
- `cpu_rst` out 1: active-high reset to the CPU PC.
- `busy` out 1: high in LOAD, DRAIN and HOLD.
- `done` out 1: high in RUN.
- `error` out 1: high in ERROR.
- `words_loaded` out `$clog2(DEPTH_WORDS+1)`: count of words accepted in the current session.

## Operation
- States are IDLE, LOAD, DRAIN, HOLD, RUN and ERROR.
- Reset values: state IDLE, `cpu_rst`=1, `initialize`=0, `instruction_initialize_data`=0, `instruction_initialize_address`=0, `busy`=`done`=`error`=0, `words_loaded`=0, internal word index 0, hold counter 0.
- IDLE: `start` moves to LOAD. `cpu_rst` stays 1.
- LOAD: `load_ready`=1, decoded combinationally from state. A beat is `load_valid & load_ready`.
  - Each beat registers `load_data` into `instruction_initialize_data` and `index*4` into `instruction_initialize_address`, pulses `initialize` for exactly the next cycle, then increments index and `words_loaded`.
  - `initialize` is 0 in any cycle not following a beat, so gaps in `load_valid` cause no spurious writes.
- A beat with `load_last`=1 moves to DRAIN.
- A beat at index `DEPTH_WORDS-1` with `load_last`=0 is an overflow: the word is still written, and the FSM moves to ERROR.
- DRAIN: one cycle in which the final `initialize` pulse is applied. The FSM then moves to HOLD with the hold counter cleared.
- HOLD: the counter increments each cycle. When it reaches `HOLD_CYCLES-1`, the FSM moves to RUN.
- RUN: `cpu_rst`=0 and `done`=1.
- ERROR: `error`=1, `cpu_rst`=1 and `load_ready`=0.
- Reload and retry: `start` in RUN or ERROR moves to LOAD, clears index and `words_loaded`, and drives `cpu_rst`=1 from the next cycle.
- `start` is ignored in LOAD, DRAIN and HOLD.
- Address arithmetic: addresses are 32 bits and word aligned; bits [1:0] are always 0. The maximum address is `(DEPTH_WORDS-1)*4`. The index never wraps.
- Reset mid-session: the next edge with `rst`=0 returns every output to its reset value. Memory contents already written are not erased.

## Timing
- `cpu_rst` is registered: it asserts in the first cycle of LOAD after `start` and deasserts in the first cycle of RUN.
- Write latency: a beat accepted at edge k presents `initialize`=1 with its data and address during cycle k→k+1, and the memory writes on edge k+1.
- Throughput is one word per cycle while `load_valid` stays high.
- Release latency: from the edge accepting the `load_last` beat to `cpu_rst` falling is 2+`HOLD_CYCLES` edges: 1 to DRAIN, 1 to HOLD, then `HOLD_CYCLES` to RUN.
- Every output is registered except `load_ready`.

## Structure
- Shared package `boot_pkg` holds the state enum (`BOOT_IDLE`, `BOOT_LOAD`, `BOOT_DRAIN`, `BOOT_HOLD`, `BOOT_RUN`, `BOOT_ERROR`) and the constant `WORD_BYTES`=4.
- Single module with one FSM, an index/word counter and a hold counter. No sub-module is warranted.
- The top level instantiating the CPU connects `cpu_rst` to the CPU `rst` and the three initialize outputs to the CPU initialize inputs.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `cpu_rst`=1, `initialize`=0, `load_ready`=0, `done`=0.
- Back-to-back load: `start`, then 3 beats 0x20010005, 0x20020003, 0x00221820 (last on the third) → `initialize` pulses at addresses 0, 4, 8 with matching data on consecutive cycles; `cpu_rst` falls 4 edges after the last beat (`HOLD_CYCLES`=2); `words_loaded`=3.
- Gapped stream: `load_valid` toggles 1,0,0,1(last) → exactly 2 `initialize` pulses at addresses 0 and 4; no pulse during the gap cycles.
- Overflow (`DEPTH_WORDS`=4): 4 beats with no `load_last` → writes at 0, 4, 8, 12; `error`=1; `cpu_rst` stays 1. `start` then reloads 1 word with last → `done`=1.
- Reset mid-LOAD: after 2 beats, drive `rst`=0 for 1 cycle → state IDLE, `words_loaded`=0, `cpu_rst`=1. A new `start` writes from address 0 again.
- Reload from RUN: `start` while `done`=1 → `cpu_rst`=1 on the next cycle, `done`=0, `load_ready`=1.

Source files
------------

// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared state encoding and address helpers for the
//                instruction-memory boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Boot sequencer states, explicitly encoded in 3 bits.
  typedef enum logic [2:0] {
    BOOT_IDLE  = 3'd0,
    BOOT_LOAD  = 3'd1,
    BOOT_DRAIN = 3'd2,
    BOOT_HOLD  = 3'd3,
    BOOT_RUN   = 3'd4,
    BOOT_ERROR = 3'd5
  } boot_state_e;

  // Bytes per instruction word; instruction memory is byte addressed.
  localparam int unsigned WORD_BYTES = 4;

  // Word index to byte address; the result is always word aligned.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx * WORD_BYTES;
  endfunction

endpackage : boot_pkg
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Streams a program image into the CPU instruction memory and
//                holds the CPU in reset until the image is fully written,
//                then releases it to start at PC 0. Supports reload from RUN
//                and retry from ERROR without a global reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [31:0]                        load_data,
  input  logic                               load_last,
  output logic                               initialize,
  output logic [31:0]                        instruction_initialize_data,
  output logic [31:0]                        instruction_initialize_address,
  output logic                               cpu_rst,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   words_loaded
);

  // Word counter must hold DEPTH_WORDS itself after an overflow beat.
  localparam int CW = $clog2(DEPTH_WORDS + 1);
  // Hold counter needs at least one bit even when HOLD_CYCLES is 1.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH_WORDS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  boot_state_e   state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          init_q, init_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          beat;

  // Ready is the only combinational output so a beat can be taken every cycle.
  assign load_ready = (state_q == BOOT_LOAD);
  assign beat       = load_valid & load_ready;

  // Next-state, write-port and counter logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    init_d  = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      BOOT_IDLE, BOOT_RUN, BOOT_ERROR: begin
        if (start) begin
          state_d = BOOT_LOAD;
          idx_d   = '0;
        end
      end
      BOOT_LOAD: begin
        if (beat) begin
          // The word is written even on overflow; only the next state differs.
          init_d = 1'b1;
          data_d = load_data;
          addr_d = word_addr(32'(idx_q));
          idx_d  = idx_q + 1'b1;
          if (load_last) begin
            state_d = BOOT_DRAIN;
          end else if (idx_q == LAST_IDX) begin
            state_d = BOOT_ERROR;
          end
        end
      end
      BOOT_DRAIN: begin
        // Final write pulse is on the bus during this cycle.
        state_d = BOOT_HOLD;
        hold_d  = '0;
      end
      BOOT_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = BOOT_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = BOOT_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_comb begin
    cpu_rst_d = (state_d != BOOT_RUN);
    busy_d    = (state_d == BOOT_LOAD) || (state_d == BOOT_DRAIN) ||
                (state_d == BOOT_HOLD);
    done_d    = (state_d == BOOT_RUN);
    error_d   = (state_d == BOOT_ERROR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BOOT_IDLE;
      idx_q     <= '0;
      hold_q    <= '0;
      init_q    <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      init_q    <= init_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign words_loaded                   = idx_q;

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Self-checking bench for imem_boot_loader with a session-level
//                reference model and a shadow instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  // Model phases: FIN covers the drain plus hold interval before release.
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_FIN  = 2;
  localparam int P_RUN  = 3;
  localparam int P_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_data = '0;
  logic          load_last = 1'b0;
  logic          initialize;
  logic [31:0]   init_data;
  logic [31:0]   init_addr;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  int          m_phase;
  int          m_count;
  int          m_rel;
  bit          m_init;
  logic [31:0] m_wdata;
  logic [31:0] m_waddr;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] tb_mem  [DEPTH];

  imem_boot_loader #(
    .DEPTH_WORDS(DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .load_valid                     (load_valid),
    .load_ready                     (load_ready),
    .load_data                      (load_data),
    .load_last                      (load_last),
    .initialize                     (initialize),
    .instruction_initialize_data    (init_data),
    .instruction_initialize_address (init_addr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .error                          (error),
    .words_loaded                   (words_loaded)
  );

  always #5 clk = ~clk;

  // Shadow instruction memory: commits a write on the edge after the strobe.
  always @(posedge clk) begin
    if (initialize && (init_addr < 32'(DEPTH * 4)) && (init_addr[1:0] == 2'b00))
      tb_mem[init_addr[3:2]] <= init_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("initialize", 32'(initialize), 32'(m_init));
    if (m_init) begin
      chk("init_addr", init_addr, m_waddr);
      chk("init_data", init_data, m_wdata);
    end
    chk("cpu_rst", 32'(cpu_rst), 32'(m_phase != P_RUN));
    chk("done", 32'(done), 32'(m_phase == P_RUN));
    chk("error", 32'(error), 32'(m_phase == P_ERR));
    chk("busy", 32'(busy), 32'((m_phase == P_LOAD) || (m_phase == P_FIN)));
    chk("words_loaded", 32'(words_loaded), 32'(m_count));
  endtask

  // One clock cycle of stimulus with the model advanced by the same rules.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit s);
    bit beat;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    start      = s;
    chk("load_ready", 32'(load_ready), 32'(m_phase == P_LOAD));
    beat = v && (m_phase == P_LOAD);
    @(posedge clk);
    #1;
    m_init = 1'b0;
    case (m_phase)
      P_IDLE, P_RUN, P_ERR: begin
        if (s) begin
          m_phase = P_LOAD;
          m_count = 0;
        end
      end
      P_LOAD: begin
        if (beat) begin
          m_init  = 1'b1;
          m_wdata = d;
          m_waddr = 32'(m_count * 4);
          ref_mem[m_count] = d;
          m_count++;
          if (l) begin
            m_phase = P_FIN;
            m_rel   = 1 + HOLD;
          end else if (m_count == DEPTH) begin
            m_phase = P_ERR;
          end
        end
      end
      P_FIN: begin
        m_rel--;
        if (m_rel == 0) m_phase = P_RUN;
      end
      default: m_phase = P_IDLE;
    endcase
    check_outputs();
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst        = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      m_phase = P_IDLE;
      m_count = 0;
      m_init  = 1'b0;
      check_outputs();
      chk("rst_data", init_data, 32'h0);
      chk("rst_addr", init_addr, 32'h0);
      chk("rst_load_ready", 32'(load_ready), 32'h0);
    end
    rst = 1'b1;
  endtask

  task automatic check_image();
    for (int i = 0; i < DEPTH; i++) chk("image_word", tb_mem[i], ref_mem[i]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      tb_mem[i]  = '0;
    end
    m_phase = P_IDLE;
    m_count = 0;
    m_rel   = 0;
    m_init  = 1'b0;
    m_wdata = '0;
    m_waddr = '0;

    // Reset held for two cycles, then idle without start.
    do_reset(2);
    step(0, 32'h0, 0, 0);
    step(1, 32'hDEAD_BEEF, 1, 0);

    // Back-to-back three-word program and release latency.
    step(0, 32'h0, 0, 1);
    step(1, 32'h2001_0005, 0, 0);
    step(1, 32'h2002_0003, 0, 0);
    step(1, 32'h0022_1820, 1, 0);
    n = 1;
    while (cpu_rst !== 1'b0 && n < 12) begin
      step(0, 32'h0, 0, 0);
      n++;
    end
    chk("release_edges", 32'(n), 32'(2 + HOLD));
    chk("b2b_words", 32'(words_loaded), 32'd3);
    step(0, 32'h0, 0, 0);
    check_image();

    // Gapped stream: valid 1,0,0,1(last); start during LOAD is ignored.
    step(0, 32'h0, 0, 1);
    step(1, 32'h1111_1111, 0, 0);
    step(0, 32'h2222_2222, 0, 1);
    step(0, 32'h3333_3333, 1, 0);
    step(1, 32'h4444_4444, 1, 0);
    repeat (HOLD + 3) step(0, 32'h0, 0, 0);
    chk("gap_words", 32'(words_loaded), 32'd2);
    check_image();

    // Overflow: DEPTH beats with no last, then retry from ERROR.
    step(0, 32'h0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 32'hA000_0000 + 32'(i), 0, 0);
    repeat (3) step(0, 32'h0, 0, 0);
    chk("ovf_error", 32'(error), 32'h1);
    check_image();
    step(0, 32'h0, 0, 1);
    step(1, 32'h5555_AAAA, 1, 0);
    repeat (HOLD + 3) step(0, 32'h0, 0, 0);
    chk("retry_done", 32'(done), 32'h1);

    // Reset mid-LOAD, then reload from address 0.
    step(0, 32'h0, 0, 1);
    step(1, 32'hB000_0000, 0, 0);
    step(1, 32'hB000_0001, 0, 0);
    do_reset(1);
    step(0, 32'h0, 0, 1);
    step(1, 32'hC0DE_0000, 1, 0);
    chk("post_rst_addr", init_addr, 32'h0);
    repeat (HOLD + 3) step(0, 32'h0, 0, 0);
    check_image();

    // Reload from RUN.
    step(0, 32'h0, 0, 1);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'h1);
    step(1, 32'hC0DE_0001, 1, 0);
    repeat (HOLD + 3) step(0, 32'h0, 0, 0);

    // Randomized sessions: length, gaps, last placement, stray starts, resets.
    for (int s = 0; s < 30; s++) begin
      bit has_last;
      bit do_rst;
      int len;
      int rst_at;
      has_last = ($urandom_range(0, 3) != 0);
      len      = has_last ? int'($urandom_range(1, DEPTH)) : DEPTH;
      do_rst   = ($urandom_range(0, 5) == 0);
      rst_at   = int'($urandom_range(0, len - 1));
      step(0, 32'h0, 0, 1);
      for (int i = 0; i < len; i++) begin
        if (do_rst && i == rst_at) begin
          do_reset(1);
          break;
        end
        repeat ($urandom_range(0, 2))
          step(0, $urandom, 0, ($urandom_range(0, 1) == 1));
        step(1, $urandom, (has_last && i == len - 1), ($urandom_range(0, 1) == 1));
      end
      repeat (HOLD + 4) step(0, 32'h0, 0, 0);
      check_image();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_imem_boot_loader
`default_nettype wire
